// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline hazard controller.
// Drives per-register control words, PC hold, memory watchdog and perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_ready_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_stall_o,
  output logic [1:0]       ctrl_if_id_o,
  output logic [1:0]       ctrl_id_ex_o,
  output logic [1:0]       ctrl_ex_mem_o,
  output logic [1:0]       ctrl_mem_wb_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0] C_DEF   = 2'b00;
  localparam logic [1:0] C_STALL = 2'b01;
  localparam logic [1:0] C_BUB   = 2'b10;

  localparam int unsigned WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_ERR
  } state_t;

  state_t            state_q;
  logic [WC_W-1:0]   wait_cnt_q;
  logic              err_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_wait;
  logic load_use;
  logic in_err;
  logic sel_rst, sel_err, sel_wait, sel_redir;
  logic sel_lu, sel_ifnr, sel_def;

  assign mem_wait = mem_req_i & ~mem_ready_i;
  assign in_err   = (state_q == S_ERR);

  assign load_use = ex_mem_read_i
                  & (ex_rd_i != 5'd0)
                  & ((ex_rd_i == id_rs1_i)
                   | (ex_rd_i == id_rs2_i));

  // One-hot rule select, highest priority first
  assign sel_rst   = rst;
  assign sel_err   = ~rst & in_err;
  assign sel_wait  = ~rst & ~in_err & mem_wait;
  assign sel_redir = ~rst & ~in_err & ~mem_wait
                   & ex_redirect_i;
  assign sel_lu    = ~rst & ~in_err & ~mem_wait
                   & ~ex_redirect_i & load_use;
  assign sel_ifnr  = ~rst & ~in_err & ~mem_wait
                   & ~ex_redirect_i & ~load_use
                   & ~if_ready_i;
  assign sel_def   = ~rst & ~in_err & ~mem_wait
                   & ~ex_redirect_i & ~load_use
                   & if_ready_i;

  // Same-cycle control word decode from state and inputs
  always_comb begin
    pc_stall_o    = 1'b0;
    ctrl_if_id_o  = C_DEF;
    ctrl_id_ex_o  = C_DEF;
    ctrl_ex_mem_o = C_DEF;
    ctrl_mem_wb_o = C_DEF;
    unique case (1'b1)
      sel_rst: begin
        pc_stall_o    = 1'b1;
        ctrl_if_id_o  = C_BUB;
        ctrl_id_ex_o  = C_BUB;
        ctrl_ex_mem_o = C_BUB;
        ctrl_mem_wb_o = C_BUB;
      end
      sel_err: begin
        pc_stall_o    = 1'b1;
        ctrl_if_id_o  = C_STALL;
        ctrl_id_ex_o  = C_STALL;
        ctrl_ex_mem_o = C_STALL;
        ctrl_mem_wb_o = C_STALL;
      end
      sel_wait: begin
        pc_stall_o    = 1'b1;
        ctrl_if_id_o  = C_STALL;
        ctrl_id_ex_o  = C_STALL;
        ctrl_ex_mem_o = C_STALL;
        ctrl_mem_wb_o = C_BUB;
      end
      sel_redir: begin
        ctrl_if_id_o  = C_BUB;
        ctrl_id_ex_o  = C_BUB;
      end
      sel_lu: begin
        pc_stall_o    = 1'b1;
        ctrl_if_id_o  = C_STALL;
        ctrl_id_ex_o  = C_BUB;
      end
      sel_ifnr: begin
        pc_stall_o    = 1'b1;
        ctrl_if_id_o  = C_BUB;
      end
      sel_def: begin
        pc_stall_o    = 1'b0;
      end
      default: begin
        pc_stall_o    = 1'b0;
      end
    endcase
  end

  // Memory-wait watchdog; ERR is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (mem_wait) begin
            state_q    <= S_MEM_WAIT;
            wait_cnt_q <= WC_W'(1);
          end
        end
        S_MEM_WAIT: begin
          if (!mem_wait) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q >= WC_LAST) begin
            state_q    <= S_ERR;
            err_q      <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WC_W'(1);
          end
        end
        S_ERR: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q    <= S_ERR;
          err_q      <= 1'b1;
        end
      endcase
    end
  end

  // Saturating performance counter next-state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!rst && pc_stall_o && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (sel_redir && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table plus corner sequences.
// Expected words are queued on drive and compared at the falling edge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       ifr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mrd;
    logic       rdr;
    logic       mreq;
    logic       mrdy;
  } in_t;

  typedef struct packed {
    logic [95:0] name;
    logic        pcs;
    logic [7:0]  ctl;
    logic        err;
    logic        chk;
    logic [7:0]  sc;
    logic [7:0]  fc;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t ex;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_ready_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       ex_mem_read_i, ex_redirect_i;
  logic       mem_req_i, mem_ready_i;
  logic       pc_stall_o, err_o;
  logic [1:0] ctrl_if_id_o, ctrl_id_ex_o;
  logic [1:0] ctrl_ex_mem_o, ctrl_mem_wb_o;
  logic [7:0] stall_cnt_o, flush_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  vec_t tbl[15];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_ready_i   (if_ready_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .ex_rd_i      (ex_rd_i),
    .ex_mem_read_i(ex_mem_read_i),
    .ex_redirect_i(ex_redirect_i),
    .mem_req_i    (mem_req_i),
    .mem_ready_i  (mem_ready_i),
    .pc_stall_o   (pc_stall_o),
    .ctrl_if_id_o (ctrl_if_id_o),
    .ctrl_id_ex_o (ctrl_id_ex_o),
    .ctrl_ex_mem_o(ctrl_ex_mem_o),
    .ctrl_mem_wb_o(ctrl_mem_wb_o),
    .err_o        (err_o),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  function automatic in_t vi(
    input logic r, input logic ifr,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic mrd,
    input logic rdr, input logic mreq,
    input logic mrdy);
    in_t v;
    v.rst = r; v.ifr = ifr;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.mrd = mrd; v.rdr = rdr;
    v.mreq = mreq; v.mrdy = mrdy;
    return v;
  endfunction

  function automatic exp_t ve(
    input logic [95:0] n, input logic pcs,
    input logic [7:0] ctl, input logic err,
    input logic chk, input logic [7:0] sc,
    input logic [7:0] fc);
    exp_t e;
    e.name = n; e.pcs = pcs; e.ctl = ctl;
    e.err = err; e.chk = chk;
    e.sc = sc; e.fc = fc;
    return e;
  endfunction

  function automatic in_t idle();
    return vi(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic in_t wt(input logic rdr);
    return vi(0, 1, 0, 0, 0, 0, rdr, 1, 0);
  endfunction

  function automatic in_t rdy(input logic rdr);
    return vi(0, 1, 0, 0, 0, 0, rdr, 1, 1);
  endfunction

  function automatic in_t rs();
    return vi(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic check();
    exp_t e;
    logic [7:0] act_ctl;
    logic bad;
    e = sb.pop_front();
    act_ctl = {ctrl_if_id_o, ctrl_id_ex_o,
               ctrl_ex_mem_o, ctrl_mem_wb_o};
    bad = (pc_stall_o !== e.pcs)
       || (act_ctl !== e.ctl)
       || (err_o !== e.err);
    if (e.chk)
      bad = bad || (stall_cnt_o !== e.sc)
                || (flush_cnt_o !== e.fc);
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %0s: got pcs=%b ctl=%b err=%b sc=%0d fc=%0d want pcs=%b ctl=%b err=%b sc=%0d fc=%0d (cnt chk %b)",
               e.name, pc_stall_o, act_ctl, err_o,
               stall_cnt_o, flush_cnt_o, e.pcs, e.ctl,
               e.err, e.sc, e.fc, e.chk);
    end
  endtask

  task automatic step(input in_t i, input exp_t e);
    rst           = i.rst;
    if_ready_i    = i.ifr;
    id_rs1_i      = i.rs1;
    id_rs2_i      = i.rs2;
    ex_rd_i       = i.rd;
    ex_mem_read_i = i.mrd;
    ex_redirect_i = i.rdr;
    mem_req_i     = i.mreq;
    mem_ready_i   = i.mrdy;
    sb.push_back(e);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] K_BUB  = 8'b10_10_10_10;
  localparam logic [7:0] K_DEF  = 8'b00_00_00_00;
  localparam logic [7:0] K_LU   = 8'b01_10_00_00;
  localparam logic [7:0] K_RD   = 8'b10_10_00_00;
  localparam logic [7:0] K_IFNR = 8'b10_00_00_00;
  localparam logic [7:0] K_WAIT = 8'b01_01_01_10;
  localparam logic [7:0] K_ERR  = 8'b01_01_01_01;

  initial begin
    rst = 1'b1;
    if_ready_i = 1'b1;
    id_rs1_i = '0; id_rs2_i = '0; ex_rd_i = '0;
    ex_mem_read_i = 1'b0; ex_redirect_i = 1'b0;
    mem_req_i = 1'b0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    tbl[0]  = '{in: rs(), ex: ve("rst0", 1, K_BUB, 0, 1, 0, 0)};
    tbl[1]  = '{in: rs(), ex: ve("rst1", 1, K_BUB, 0, 1, 0, 0)};
    tbl[2]  = '{in: idle(), ex: ve("idle", 0, K_DEF, 0, 1, 0, 0)};
    tbl[3]  = '{in: vi(0, 1, 0, 5, 5, 1, 0, 0, 0),
                ex: ve("lu_rs2", 1, K_LU, 0, 1, 0, 0)};
    tbl[4]  = '{in: idle(), ex: ve("lu_after", 0, K_DEF, 0, 1, 1, 0)};
    tbl[5]  = '{in: vi(0, 1, 7, 0, 7, 1, 0, 0, 0),
                ex: ve("lu_rs1", 1, K_LU, 0, 1, 1, 0)};
    tbl[6]  = '{in: vi(0, 1, 0, 0, 0, 1, 0, 0, 0),
                ex: ve("lu_x0", 0, K_DEF, 0, 1, 2, 0)};
    tbl[7]  = '{in: vi(0, 1, 5, 0, 5, 0, 0, 0, 0),
                ex: ve("noload", 0, K_DEF, 0, 1, 2, 0)};
    tbl[8]  = '{in: vi(0, 1, 6, 7, 5, 1, 0, 0, 0),
                ex: ve("lu_miss", 0, K_DEF, 0, 1, 2, 0)};
    tbl[9]  = '{in: vi(0, 0, 0, 0, 0, 0, 0, 0, 0),
                ex: ve("ifnr", 1, K_IFNR, 0, 1, 2, 0)};
    tbl[10] = '{in: vi(0, 1, 5, 0, 5, 1, 1, 0, 0),
                ex: ve("redir_lu", 0, K_RD, 0, 1, 3, 0)};
    tbl[11] = '{in: idle(), ex: ve("redir_aft", 0, K_DEF, 0, 1, 3, 1)};
    tbl[12] = '{in: vi(0, 0, 0, 0, 0, 0, 1, 0, 0),
                ex: ve("redir_ifnr", 0, K_RD, 0, 1, 3, 1)};
    tbl[13] = '{in: vi(0, 0, 9, 0, 9, 1, 0, 0, 0),
                ex: ve("lu_ifnr", 1, K_LU, 0, 1, 3, 2)};
    tbl[14] = '{in: idle(), ex: ve("idle2", 0, K_DEF, 0, 1, 4, 2)};

    for (int i = 0; i < 15; i++)
      step(tbl[i].in, tbl[i].ex);

    // Three wait cycles then ready
    step(rs(),     ve("b_rst", 1, K_BUB, 0, 0, 0, 0));
    step(wt(0),    ve("b_w1", 1, K_WAIT, 0, 1, 0, 0));
    step(wt(0),    ve("b_w2", 1, K_WAIT, 0, 1, 1, 0));
    step(wt(0),    ve("b_w3", 1, K_WAIT, 0, 1, 2, 0));
    step(rdy(0),   ve("b_rdy", 0, K_DEF, 0, 1, 3, 0));
    step(idle(),   ve("b_idle", 0, K_DEF, 0, 1, 3, 0));

    // Redirect held across a memory wait
    step(rs(),     ve("c_rst", 1, K_BUB, 0, 0, 0, 0));
    step(wt(1),    ve("c_w1", 1, K_WAIT, 0, 1, 0, 0));
    step(vi(0, 0, 3, 0, 3, 1, 1, 1, 0),
                   ve("c_w2", 1, K_WAIT, 0, 1, 1, 0));
    step(rdy(1),   ve("c_rdy", 0, K_RD, 0, 1, 2, 0));
    step(idle(),   ve("c_idle", 0, K_DEF, 0, 1, 2, 1));

    // Watchdog expiry, sticky until reset
    step(rs(),     ve("d_rst", 1, K_BUB, 0, 0, 0, 0));
    step(wt(0),    ve("d_w1", 1, K_WAIT, 0, 1, 0, 0));
    step(wt(0),    ve("d_w2", 1, K_WAIT, 0, 1, 1, 0));
    step(wt(0),    ve("d_w3", 1, K_WAIT, 0, 1, 2, 0));
    step(wt(0),    ve("d_w4", 1, K_WAIT, 0, 1, 3, 0));
    step(wt(0),    ve("d_err", 1, K_ERR, 1, 1, 4, 0));
    step(rdy(0),   ve("d_errrdy", 1, K_ERR, 1, 1, 5, 0));
    step(vi(0, 1, 0, 0, 0, 0, 1, 0, 0),
                   ve("d_errrd", 1, K_ERR, 1, 1, 6, 0));
    step(rs(),     ve("d_rst2", 1, K_BUB, 1, 0, 0, 0));
    step(idle(),   ve("d_clear", 0, K_DEF, 0, 1, 0, 0));

    // Ready on the timeout cycle, then wait count restarts
    step(rs(),     ve("e_rst", 1, K_BUB, 0, 0, 0, 0));
    step(wt(0),    ve("e_w1", 1, K_WAIT, 0, 1, 0, 0));
    step(wt(0),    ve("e_w2", 1, K_WAIT, 0, 1, 1, 0));
    step(wt(0),    ve("e_w3", 1, K_WAIT, 0, 1, 2, 0));
    step(rdy(0),   ve("e_rdy", 0, K_DEF, 0, 1, 3, 0));
    step(wt(0),    ve("e_w1b", 1, K_WAIT, 0, 1, 3, 0));
    step(wt(0),    ve("e_w2b", 1, K_WAIT, 0, 1, 4, 0));
    step(wt(0),    ve("e_w3b", 1, K_WAIT, 0, 1, 5, 0));
    step(idle(),   ve("e_drop", 0, K_DEF, 0, 1, 6, 0));
    step(idle(),   ve("e_idle", 0, K_DEF, 0, 1, 6, 0));

    // Stall counter saturation
    step(rs(),     ve("f_rst", 1, K_BUB, 0, 0, 0, 0));
    for (int i = 0; i < 260; i++)
      step(vi(0, 0, 0, 0, 0, 0, 0, 0, 0),
           ve("f_ssat", 1, K_IFNR, 0, 1,
              (i < 255) ? 8'(i) : 8'hFF, 0));

    // Flush counter saturation
    step(rs(),     ve("g_rst", 1, K_BUB, 0, 0, 0, 0));
    for (int i = 0; i < 260; i++)
      step(vi(0, 1, 0, 0, 0, 0, 1, 0, 0),
           ve("g_fsat", 0, K_RD, 0, 1, 0,
              (i < 255) ? 8'(i) : 8'hFF));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
